// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, handshakes it to instruction memory, and applies
// trap/redirect/halt control. Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirects.
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_2000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
  parameter int unsigned     INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            fetch_kill,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam int unsigned     ALIGN_BITS = $clog2(INST_BYTES);
  localparam logic [XLEN-1:0] AlignMask  = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PcInc      = XLEN'(INST_BYTES);

  typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pend_misalign_q, pend_misalign_d;

  logic            fire;
  logic            ev_valid;
  logic [XLEN-1:0] ev_target;
  logic            ev_misalign;
  logic            apply_misalign;

  assign pc_valid = (state_q == StFetch);
  assign halted   = (state_q == StHalted);
  assign pc       = pc_q;
  assign fire     = pc_valid & pc_ready;
  assign ev_valid = trap_valid | redir_valid;

  // Resolve the incoming event to its effective target; trap outranks redirect.
  always_comb begin
    ev_target   = TRAP_VEC;
    ev_misalign = 1'b0;
    if (!trap_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
      ev_misalign = |redir_target[ALIGN_BITS-1:0];
      ev_target   = ev_misalign ? TRAP_VEC : redir_target;
`else
      ev_target   = redir_target & ~AlignMask;
`endif
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0] pend_raw_q, pend_raw_d;
  logic [XLEN-1:0] apply_raw;
  logic [XLEN-1:0] misalign_addr_q;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_valid_d    = pend_valid_q;
    pend_trap_d     = pend_trap_q;
    pend_target_d   = pend_target_q;
    pend_misalign_d = pend_misalign_q;
    fetch_kill      = 1'b0;
    apply_misalign  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    pend_raw_d      = pend_raw_q;
    apply_raw       = redir_target;
`endif
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
        if (ev_valid) begin
          pc_d           = ev_target;
          apply_misalign = ev_misalign;
        end
      end
      StFetch: begin
        if (!fire) begin
          // Outstanding: buffer the event; a pending trap is never displaced by a redirect.
          if (ev_valid && (trap_valid || !(pend_valid_q && pend_trap_q))) begin
            pend_valid_d    = 1'b1;
            pend_trap_d     = trap_valid;
            pend_target_d   = ev_target;
            pend_misalign_d = ev_misalign;
`ifdef PC_MISALIGN_TRAP_EN
            pend_raw_d      = redir_target;
`endif
          end
        end else begin
          fetch_kill   = ev_valid | pend_valid_q;
          pend_valid_d = 1'b0;
          if (ev_valid && (trap_valid || !(pend_valid_q && pend_trap_q))) begin
            pc_d           = ev_target;
            apply_misalign = ev_misalign;
          end else if (pend_valid_q) begin
            pc_d           = pend_target_q;
            apply_misalign = pend_misalign_q;
`ifdef PC_MISALIGN_TRAP_EN
            apply_raw      = pend_raw_q;
`endif
          end else if (!stall && !halt_req) begin
            pc_d = pc_q + PcInc;
          end
          if (halt_req) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        if (ev_valid) begin
          pc_d           = ev_target;
          apply_misalign = ev_misalign;
        end
        if (resume && !halt_req) begin
          state_d = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StBoot;
      pc_q            <= RESET_VEC;
      pend_valid_q    <= 1'b0;
      pend_trap_q     <= 1'b0;
      pend_target_q   <= '0;
      pend_misalign_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_valid_q    <= pend_valid_d;
      pend_trap_q     <= pend_trap_d;
      pend_target_q   <= pend_target_d;
      pend_misalign_q <= pend_misalign_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_raw_q      <= '0;
      misalign_addr_q <= '0;
    end else begin
      pend_raw_q <= pend_raw_d;
      if (apply_misalign) begin
        misalign_addr_q <= apply_raw;
      end
    end
  end

  assign misalign_err  = apply_misalign;
  assign misalign_addr = misalign_addr_q;
`else
  assign misalign_err  = apply_misalign;
  assign misalign_addr = '0;
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for stage1. It holds the architectural fetch PC and presents it to instruction memory over a valid/ready handshake, and it advances by one instruction per accepted fetch. It also accepts redirects from stage2 (branch/jump) and traps, with a defined priority, and supports a halt/resume state machine. Any redirect that arrives while a fetch is outstanding is buffered and marked so the wrong-path instruction can be killed downstream.

## Interface
- XLEN, 32, address width in bits
- RESET_VEC, 32'h0000_2000, PC value after reset
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect
- INST_BYTES, 4, sequential increment; power of two ≥ 2; ALIGN_BITS = log2(INST_BYTES)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC; suppresses sequential advance only
- redir_valid  in  1  stage2 redirect request, single-cycle pulse
- redir_target  in  XLEN  redirect address
- trap_valid  in  1  trap request, single-cycle pulse
- halt_req  in  1  request transition to HALTED
- resume  in  1  leave HALTED
- pc_ready  in  1  instruction memory accepts pc
- pc  out  XLEN  current fetch address, registered
- pc_valid  out  1  pc is a live fetch request
- fetch_kill  out  1  the fetch accepted this cycle is wrong-path
- halted  out  1  FSM in HALTED
- misalign_err  out  1  one-cycle pulse, misaligned redirect trapped
- misalign_addr  out  XLEN  last offending redirect target

## Operation
- Reset (async): pc=RESET_VEC, state=BOOT, pc_valid=0, fetch_kill=0, halted=0, misalign_err=0, misalign_addr=0, pend_valid=0.
- FSM states:
  - BOOT: pc_valid=0; moves unconditionally to FETCH next cycle.
  - FETCH: pc_valid=1.
  - HALTED: pc_valid=0, halted=1.
- fire = pc_valid & pc_ready. outstanding = pc_valid & ~pc_ready.
- Handshake rule: while outstanding, pc and pc_valid are held stable.
- Next-PC priority: trap_valid > redir_valid > stall > sequential.
  - trap: target = TRAP_VEC.
  - redirect: target = redir_target.
  - sequential: on fire & ~stall, pc <= pc + INST_BYTES, wrapping modulo 2^XLEN.
- Redirect or trap when not outstanding: pc <= target next cycle, regardless of stall.
- Redirect or trap while outstanding: target goes into the pend register (pend_valid=1). A later redirect overwrites it, but only with equal or higher priority. On the fire cycle: fetch_kill=1, pc <= pend target, pend_valid <= 0.
- Redirect coincident with fire: fetch_kill=1, pc <= target. No pend entry is used.
- halt_req is honoured in FETCH only when not outstanding. Next state is HALTED and pc is held.
- In HALTED:
  - redirect/trap update pc immediately.
  - resume returns to FETCH.
  - halt_req and resume together: stay HALTED.
- halt_req in BOOT is deferred until FETCH.

## Timing
- Redirect at cycle N with no fetch outstanding: pc=target and pc_valid=1 at N+1.
- Sequential latency: fire at N gives pc+INST_BYTES at N+1.
- Reset release at N: BOOT at N, first pc_valid=1 at N+1 with pc=RESET_VEC.
- fetch_kill and misalign_err are combinational from registered state and current inputs, asserted only in the fire or trigger cycle.
- Reset asserted mid-handshake: all state clears immediately and pend is discarded.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect with redir_target[ALIGN_BITS-1:0] != 0 is replaced by TRAP_VEC.
  - misalign_err pulses in the cycle the redirect is applied (directly or from pend).
  - misalign_addr captures redir_target.
- PC_MISALIGN_TRAP_EN undefined:
  - The redirect target's low ALIGN_BITS bits are forced to zero.
  - misalign_err is tied 0 and misalign_addr is tied 0.

## Test plan
- Reset then pc_ready=1, no stall, 4 cycles: pc_valid rises 1 cycle after release; pc = 0x2000, 0x2004, 0x2008, 0x200C.
- pc_ready=0 for 3 cycles with redir_valid pulse to 0x4000 mid-wait: pc holds 0x2004; on the fire cycle fetch_kill=1; the next pc is 0x4000.
- stall=1 with redir_valid to 0x3000 and trap_valid in the same cycle: next pc is 0x0100 (trap wins over redirect and stall).
- halt_req while idle-ready: halted=1 and pc_valid=0 next cycle. A redirect to 0x5000 while HALTED gives pc=0x5000. resume gives pc_valid=1 at 0x5000.
- Redirect to 0x4002 with macro defined: pc=0x0100, misalign_err=1 for one cycle, misalign_addr=0x4002. With the macro undefined: pc=0x4000 and misalign_err=0.
- XLEN=32, pc=0xFFFF_FFFC with a sequential fire: pc wraps to 0x0000_0000.
